// File: rtl/kmeans_assign_sched.sv
// kmeans_assign_sched: nearest-centroid scheduler sequencing a shared fixed-latency distance unit.
// Optional macro KMEANS_SCHED_MASK_EN adds the per-point cent_en centroid mask.
module kmeans_assign_sched #(
    parameter int K        = 4,
    parameter int IDX_W    = 2,
    parameter int DIST_LAT = 3
) (
    input  logic             sched_clk,
    input  logic             sched_rst,
    input  logic             cent_we,
    input  logic [IDX_W-1:0] cent_idx,
    input  logic [9:0]       cent_x,
    input  logic [9:0]       cent_y,
`ifdef KMEANS_SCHED_MASK_EN
    input  logic [K-1:0]     cent_en,
`endif
    input  logic             pt_valid,
    output logic             pt_ready,
    input  logic [9:0]       pt_x,
    input  logic [9:0]       pt_y,
    output logic [9:0]       dist_X1,
    output logic [9:0]       dist_Y1,
    output logic [9:0]       dist_X2,
    output logic [9:0]       dist_Y2,
    input  logic [31:0]      dist_Q,
    input  logic [31:0]      dist_R,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [IDX_W-1:0] res_idx,
    output logic [31:0]      res_Q,
    output logic [31:0]      res_R,
    output logic             sched_busy
);
    localparam int CNT_W = $clog2(DIST_LAT + 2);
    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
    state_t state, state_nx;
    logic [9:0] tab_x [K];
    logic [9:0] tab_y [K];
    logic [9:0] px, py, hx1, hy1, hx2, hy2;
    logic [IDX_W-1:0] j, best_idx;
    logic [CNT_W-1:0] cnt;
    logic [31:0] best_q, best_r;
    logic [K-1:0] en;
    logic accept, sample, step, last, better;
`ifdef KMEANS_SCHED_MASK_EN
    always_ff @(posedge sched_clk)
        if (!sched_rst) en <= '1;
        else if (accept) en <= cent_en;
`else
    assign en = '1;
`endif
    assign accept = state == IDLE && pt_valid;
    assign sample = state == EVAL && en[j] && cnt == CNT_W'(DIST_LAT);
    assign step   = state == EVAL && (!en[j] || sample);
    assign last   = j == IDX_W'(K - 1);
    assign better = dist_Q < best_q || (dist_Q == best_q && dist_R < best_r);
    always_ff @(posedge sched_clk)
        if (!sched_rst) state <= IDLE;
        else state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (pt_valid ? EVAL : IDLE) :
                   state == EVAL ? (step && last ? DONE : EVAL) :
                   (res_ready ? IDLE : DONE);
    // Distance inputs follow the table live in EVAL and replay the last driven value elsewhere.
    always_comb begin
        pt_ready   = state == IDLE;
        sched_busy = state != IDLE;
        res_valid  = state == DONE;
        dist_X1    = state == EVAL ? px : hx1;
        dist_Y1    = state == EVAL ? py : hy1;
        dist_X2    = state == EVAL ? tab_x[j] : hx2;
        dist_Y2    = state == EVAL ? tab_y[j] : hy2;
    end
    always_ff @(posedge sched_clk)
        if (!sched_rst) begin
            for (int i = 0; i < K; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
            end
        end else if (state == IDLE && cent_we && int'(cent_idx) < K) begin
            tab_x[cent_idx] <= cent_x;
            tab_y[cent_idx] <= cent_y;
        end
    always_ff @(posedge sched_clk)
        if (!sched_rst) begin
            {px, py, hx1, hy1, hx2, hy2} <= '0;
            j        <= '0;
            cnt      <= '0;
            best_q   <= '0;
            best_r   <= '0;
            best_idx <= '0;
            res_idx  <= '0;
            res_Q    <= '0;
            res_R    <= '0;
        end else if (accept) begin
            px       <= pt_x;
            py       <= pt_y;
            j        <= '0;
            cnt      <= '0;
            best_q   <= '1;
            best_r   <= '1;
            best_idx <= '0;
        end else if (state == EVAL) begin
            hx1 <= px;
            hy1 <= py;
            hx2 <= tab_x[j];
            hy2 <= tab_y[j];
            cnt <= step ? '0 : cnt + 1'b1;
            j   <= step && !last ? j + 1'b1 : j;
            if (sample && better) begin
                best_q   <= dist_Q;
                best_r   <= dist_R;
                best_idx <= j;
            end
            if (step && last) begin
                res_idx <= sample && better ? j : best_idx;
                res_Q   <= sample && better ? dist_Q : best_q;
                res_R   <= sample && better ? dist_R : best_r;
            end
        end
endmodule

// File: doc/kmeans_assign_sched.md
# kmeans_assign_sched

Sequencing controller for the K-means assignment step. It holds a table of K centroids and accepts one sample point at a time. For each centroid it drives the point/centroid coordinates into the shared `Calculation_distance` unit and samples the quotient/remainder pair after that unit's fixed latency. It keeps the running minimum and returns the nearest centroid index with its distance, ahead of the cluster-update logic.

## Interface
Parameters:
- `K`, 4, number of centroids (2..16)
- `IDX_W`, 2, width of centroid index, ≥ clog2(K)
- `DIST_LAT`, 3, clock cycles from stable distance inputs to valid `distance_outQ`/`distance_outR`

Ports:
- `sched_clk` in 1: sole clock, rising edge
- `sched_rst` in 1: reset, synchronous, active-low
- `cent_we` in 1: centroid table write strobe
- `cent_idx` in IDX_W: centroid index to write
- `cent_x`, `cent_y` in 10 each: centroid coordinates
- `pt_valid` in 1 / `pt_ready` out 1: point handshake
- `pt_x`, `pt_y` in 10 each: sample point
- `dist_X1`, `dist_Y1` out 10 each: point coordinates to distance unit
- `dist_X2`, `dist_Y2` out 10 each: centroid coordinates to distance unit
- `dist_Q`, `dist_R` in 32 each: distance unit quotient (isqrt) and remainder
- `res_valid` out 1 / `res_ready` in 1: result handshake
- `res_idx` out IDX_W: nearest centroid
- `res_Q`, `res_R` out 32 each: its distance pair
- `sched_busy` out 1: high when not in IDLE

## Operation
- FSM states:
  - IDLE: `pt_ready`=1. On `pt_valid`, latch `pt_x`/`pt_y`, set j=0, cnt=0, best_Q=0xFFFFFFFF, best_R=0xFFFFFFFF, best_idx=0, go to EVAL.
  - EVAL: drive `dist_X1`/`dist_Y1`=latched point and `dist_X2`/`dist_Y2`=centroid[j], held stable. cnt increments each cycle. When cnt==DIST_LAT, sample `dist_Q`/`dist_R` and compare.
    - If j==K-1, go to DONE.
    - Otherwise j++ and cnt=0.
  - DONE: `res_valid`=1 and outputs held stable. On `res_ready`, go to IDLE.
- Compare rule: the candidate replaces best iff (Q < best_Q) or (Q == best_Q and R < best_R). Ties keep the lower index.
- Centroid writes:
  - Accepted only in IDLE.
  - A `cent_we` in any other state, or with `cent_idx` ≥ K, is dropped silently.
  - A write and point acceptance in the same IDLE cycle: the write lands first, and the new point uses the updated table from its first EVAL cycle.
- Distance outputs in IDLE/DONE hold their last driven values.
- Reset (any state, including mid-EVAL or mid-DONE):
  - FSM to IDLE, j=cnt=0.
  - Centroid table cleared to (0,0).
  - `res_valid`=0, `res_idx`=0, `res_Q`=`res_R`=0.
  - `dist_*`=0, `sched_busy`=0, `pt_ready`=1 after reset release.
- Arithmetic: unsigned compares only. The coordinate difference is computed inside the distance unit, not here.

## Timing
- Point accepted at edge T0. Centroid j is sampled at edge T0+(j+1)(DIST_LAT+1).
- `res_valid` rises the cycle after the last sample: latency K·(DIST_LAT+1)+1 cycles from acceptance (17 for defaults).
- Throughput: one point per latency+1 cycles when `res_ready` is held high.
- `pt_ready` is combinational from state only (no path from `pt_valid`).
- `res_valid` never drops without `res_ready`.

## Configuration
- `KMEANS_SCHED_MASK_EN` defined:
  - Adds input `cent_en[K-1:0]`, sampled at point acceptance.
  - A disabled centroid spends exactly one EVAL cycle with no sample and no compare.
  - If all are disabled, the result is idx 0 with Q=R=0xFFFFFFFF.
- Undefined: no port is added and all K centroids are always evaluated.

## Test plan
- Behavioural distance model (isqrt with remainder, DIST_LAT=3). Centroids (10,35),(50,50),(0,0),(1023,1023); point (47,54) -> `res_idx`=1, `res_Q`=5, `res_R`=0, `res_valid` exactly 17 cycles after acceptance.
- Tie: centroid 2 set to (44,58) (also distance²=25) -> `res_idx`=1.
- Remainder tiebreak: point (0,0), centroids (5,0) (Q5 R0) at idx 3 and (5,1) (Q5 R1) at idx 0 -> `res_idx`=3.
- Backpressure: `res_ready` low for 5 cycles -> `res_*` stable, `pt_ready`=0, new `pt_valid` ignored. Write attempted during EVAL -> table unchanged.
- Reset asserted mid-EVAL (j=2) -> next cycle IDLE, `res_valid`=0, table zeroed. A fresh point (3,4) then gives idx 0, Q5 R0.
- With `KMEANS_SCHED_MASK_EN`: `cent_en`=4'b1101 on the first scenario -> `res_idx`=0 (Q41 R49), latency 3·4+1+1=14 cycles.
